// File: rtl/prog_load_dump.sv
// Program preload / memory dump engine: streams bytes into RAM while the CPU is held,
// then releases the CPU and, on request, reads RAM back out as assembled words.
module prog_load_dump #(
  parameter int ADDR_W     = 8,
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  input  logic [BYTE_W-1:0]            in_data_i,
  input  logic                         in_last_i,
  output logic                         in_ready_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [BYTE_W-1:0]            mem_wdata_o,
  output logic                         mem_we_o,
  output logic                         mem_re_o,
  input  logic [BYTE_W-1:0]            mem_rdata_i,
  input  logic                         dump_start_i,
  input  logic [ADDR_W-1:0]            dump_base_i,
  input  logic [ADDR_W-1:0]            dump_words_i,
  output logic                         out_valid_o,
  output logic [WORD_BYTES*BYTE_W-1:0] out_word_o,
  output logic [ADDR_W-1:0]            out_addr_o,
  input  logic                         out_ready_i,
  output logic                         cpu_enable_o,
  output logic                         loaded_o,
  output logic [ADDR_W:0]              byte_count_o,
  output logic                         overflow_o
);

  localparam int WORD_W = WORD_BYTES * BYTE_W;
  localparam int IDX_W  = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_RD, S_OUT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     byteCount_q, byteCount_d;
  logic                loaded_q, loaded_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   wordAddr_q, wordAddr_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rdPend_q;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   wordShift;

  // Read data arrives one cycle after mem_re; shift it in from the side matching the byte order.
  generate
    if (WORD_BYTES == 1) begin : g_one
      assign wordShift = mem_rdata_i;
    end else if (BIG_ENDIAN) begin : g_be
      assign wordShift = {word_q[WORD_W-BYTE_W-1:0], mem_rdata_i};
    end else begin : g_le
      assign wordShift = {mem_rdata_i, word_q[WORD_W-1:BYTE_W]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_LOAD;
      byteCount_q <= '0;
      loaded_q    <= 1'b0;
      overflow_q  <= 1'b0;
      cur_q       <= '0;
      wordAddr_q  <= '0;
      remain_q    <= '0;
      idx_q       <= '0;
      rdPend_q    <= 1'b0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      byteCount_q <= byteCount_d;
      loaded_q    <= loaded_d;
      overflow_q  <= overflow_d;
      cur_q       <= cur_d;
      wordAddr_q  <= wordAddr_d;
      remain_q    <= remain_d;
      idx_q       <= idx_d;
      rdPend_q    <= mem_re_o;
      word_q      <= word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byteCount_d  = byteCount_q;
    loaded_d     = loaded_q;
    overflow_d   = overflow_q;
    cur_d        = cur_q;
    wordAddr_d   = wordAddr_q;
    remain_d     = remain_q;
    idx_d        = idx_q;
    word_d       = rdPend_q ? wordShift : word_q;
    in_ready_o   = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    out_valid_o  = 1'b0;
    cpu_enable_o = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (!byteCount_q[ADDR_W]) begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = byteCount_q[ADDR_W-1:0];
            mem_wdata_o = in_data_i;
            byteCount_d = byteCount_q + (ADDR_W+1)'(1);
            if (in_last_i) begin
              loaded_d = 1'b1;
              state_d  = S_RUN;
            end
          end
        end else begin
          if (in_valid_i) overflow_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_enable_o = 1'b1;
        if (dump_start_i && dump_words_i != '0) begin
          cur_d      = dump_base_i;
          wordAddr_d = dump_base_i;
          remain_d   = dump_words_i;
          idx_d      = '0;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        if (idx_q != LAST_IDX) begin
          mem_re_o   = 1'b1;
          mem_addr_o = cur_q;
          cur_d      = cur_q + ADDR_W'(1);
          idx_d      = idx_q + IDX_W'(1);
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        // The handshake cycle already issues the next word's first read to keep one word per WORD_BYTES+1 cycles.
        if (out_ready_i) begin
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q != ADDR_W'(1)) begin
            mem_re_o   = 1'b1;
            mem_addr_o = cur_q;
            cur_d      = cur_q + ADDR_W'(1);
            wordAddr_d = cur_q;
            idx_d      = IDX_W'(1);
            state_d    = S_RD;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign out_word_o   = word_q;
  assign out_addr_o   = wordAddr_q;
  assign loaded_o     = loaded_q;
  assign byte_count_o = byteCount_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_prog_load_dump.sv
// Bench for prog_load_dump: big- and little-endian instances share stimulus, each with its own RAM,
// dumped words are checked against a scoreboard built from the bench's own copy of memory.
module tb_prog_load_dump;

  localparam int AW = 4;
  localparam int BW = 8;
  localparam int WB = 4;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       expReady;
    logic       expWe;
    logic [3:0] expAddr;
  } loadVec_t;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  addr;
  } expWord_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic inValid = 1'b0, inLast = 1'b0, dumpStart = 1'b0, outReady = 1'b0;
  logic [7:0] inData = '0;
  logic [3:0] dumpBase = '0, dumpWords = '0;

  logic beReady, beWe, beRe, beOutValid, beCpuEnable, beLoaded, beOverflow;
  logic [3:0] beMemAddr, beOutAddr;
  logic [7:0] beWdata, beRdata;
  logic [31:0] beOutWord;
  logic [4:0] beByteCount;

  logic leReady, leWe, leRe, leOutValid, leCpuEnable, leLoaded, leOverflow;
  logic [3:0] leMemAddr, leOutAddr;
  logic [7:0] leWdata, leRdata;
  logic [31:0] leOutWord;
  logic [4:0] leByteCount;

  logic [7:0] ramBe [16];
  logic [7:0] ramLe [16];
  logic [7:0] refMem [16];

  expWord_t qBe[$];
  expWord_t qLe[$];
  logic [3:0] readAddrs[$];
  logic logReads = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_load_dump #(.ADDR_W(AW), .BYTE_W(BW), .WORD_BYTES(WB), .BIG_ENDIAN(1'b1)) dutBe (
    .clk_i(clk), .rst_ni(rstN),
    .in_valid_i(inValid), .in_data_i(inData), .in_last_i(inLast), .in_ready_o(beReady),
    .mem_addr_o(beMemAddr), .mem_wdata_o(beWdata), .mem_we_o(beWe), .mem_re_o(beRe), .mem_rdata_i(beRdata),
    .dump_start_i(dumpStart), .dump_base_i(dumpBase), .dump_words_i(dumpWords),
    .out_valid_o(beOutValid), .out_word_o(beOutWord), .out_addr_o(beOutAddr), .out_ready_i(outReady),
    .cpu_enable_o(beCpuEnable), .loaded_o(beLoaded), .byte_count_o(beByteCount), .overflow_o(beOverflow)
  );

  prog_load_dump #(.ADDR_W(AW), .BYTE_W(BW), .WORD_BYTES(WB), .BIG_ENDIAN(1'b0)) dutLe (
    .clk_i(clk), .rst_ni(rstN),
    .in_valid_i(inValid), .in_data_i(inData), .in_last_i(inLast), .in_ready_o(leReady),
    .mem_addr_o(leMemAddr), .mem_wdata_o(leWdata), .mem_we_o(leWe), .mem_re_o(leRe), .mem_rdata_i(leRdata),
    .dump_start_i(dumpStart), .dump_base_i(dumpBase), .dump_words_i(dumpWords),
    .out_valid_o(leOutValid), .out_word_o(leOutWord), .out_addr_o(leOutAddr), .out_ready_i(outReady),
    .cpu_enable_o(leCpuEnable), .loaded_o(leLoaded), .byte_count_o(leByteCount), .overflow_o(leOverflow)
  );

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (beWe) ramBe[beMemAddr] <= beWdata;
    if (beRe) beRdata <= ramBe[beMemAddr];
    if (leWe) ramLe[leMemAddr] <= leWdata;
    if (leRe) leRdata <= ramLe[leMemAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expectedWord(input logic [3:0] base, input bit bigEnd);
    logic [31:0] w;
    logic [3:0] a;
    w = '0;
    for (int k = 0; k < WB; k++) begin
      a = base + 4'(k);
      if (bigEnd) w[31-8*k -: 8] = refMem[a];
      else        w[8*k +: 8]    = refMem[a];
    end
    return w;
  endfunction

  task automatic pushDump(input logic [3:0] base, input int words);
    logic [3:0] a;
    for (int w = 0; w < words; w++) begin
      a = base + 4'(4 * w);
      qBe.push_back('{word: expectedWord(a, 1'b1), addr: a});
      qLe.push_back('{word: expectedWord(a, 1'b0), addr: a});
    end
  endtask

  // Scoreboard pops happen on the cycle the word is handed off.
  always @(negedge clk) begin
    expWord_t e;
    if (rstN && beOutValid && outReady) begin
      if (qBe.size() == 0) checkOutput("beUnexpectedWord", beOutWord, 32'h0);
      else begin
        e = qBe.pop_front();
        checkOutput("beWord", beOutWord, e.word);
        checkOutput("beAddr", 32'(beOutAddr), 32'(e.addr));
      end
    end
    if (rstN && leOutValid && outReady) begin
      if (qLe.size() == 0) checkOutput("leUnexpectedWord", leOutWord, 32'h0);
      else begin
        e = qLe.pop_front();
        checkOutput("leWord", leOutWord, e.word);
        checkOutput("leAddr", 32'(leOutAddr), 32'(e.addr));
      end
    end
    if (beWe && beRe) checkOutput("beWeReExclusive", 32'(beWe & beRe), 32'h0);
    if (logReads && beRe) readAddrs.push_back(beMemAddr);
  end

  task automatic applyStimulus(input loadVec_t v);
    @(posedge clk);
    #1;
    inValid = v.valid;
    inData  = v.data;
    inLast  = v.last;
    @(negedge clk);
    checkOutput("inReady", 32'(beReady), 32'(v.expReady));
    checkOutput("memWe", 32'(beWe), 32'(v.expWe));
    checkOutput("leMemWe", 32'(leWe), 32'(v.expWe));
    checkOutput("cpuEnDuringLoad", 32'(beCpuEnable), 32'h0);
    if (v.expWe) begin
      checkOutput("memAddr", 32'(beMemAddr), 32'(v.expAddr));
      checkOutput("memWdata", 32'(beWdata), 32'(v.data));
      refMem[v.expAddr] = v.data;
    end
  endtask

  task automatic startDump(input logic [3:0] base, input logic [3:0] words);
    @(posedge clk);
    #1;
    dumpStart = 1'b1;
    dumpBase  = base;
    dumpWords = words;
    @(posedge clk);
    #1;
    dumpStart = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      idle = beCpuEnable && leCpuEnable && qBe.size() == 0 && qLe.size() == 0;
      if (idle) break;
    end
    checkOutput("idleReached", 32'(idle), 32'h1);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    qBe.delete();
    qLe.delete();
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    loadVec_t loadTab[8];
    loadVec_t overTab[17];
    logic [3:0] expRd;
    int firstAt, secondAt, got;

    for (int i = 0; i < 8; i++)
      loadTab[i] = '{valid: 1'b1, data: 8'(i + 1), last: (i == 7), expReady: 1'b1, expWe: 1'b1, expAddr: 4'(i)};
    for (int i = 0; i < 17; i++)
      overTab[i] = '{valid: 1'b1, data: 8'(8'h10 + i), last: 1'b0, expReady: (i < 16), expWe: (i < 16), expAddr: 4'(i)};

    // Reset values
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    #12;
    checkOutput("rstInReady", 32'(beReady), 32'h1);
    checkOutput("rstCpuEn", 32'(beCpuEnable), 32'h0);
    checkOutput("rstLoaded", 32'(beLoaded), 32'h0);
    checkOutput("rstByteCount", 32'(beByteCount), 32'h0);
    checkOutput("rstOutValid", 32'(beOutValid), 32'h0);
    checkOutput("rstMemWeRe", 32'({beWe, beRe}), 32'h0);
    @(posedge clk);
    #1 rstN = 1'b1;

    // Load 01..08 with last on the 8th byte
    foreach (loadTab[i]) applyStimulus(loadTab[i]);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    @(negedge clk);
    checkOutput("loadCpuEn", 32'(beCpuEnable), 32'h1);
    checkOutput("loadLoaded", 32'(beLoaded), 32'h1);
    checkOutput("loadByteCount", 32'(beByteCount), 32'd8);
    checkOutput("loadInReadyOff", 32'(beReady), 32'h0);
    for (int i = 0; i < 8; i++) checkOutput("ramContents", 32'(ramBe[i]), 32'(i + 1));

    // Dump 2 words with out_ready high: latency and throughput
    outReady = 1'b1;
    pushDump(4'd0, 2);
    @(posedge clk);
    #1;
    dumpStart = 1'b1;
    dumpBase  = 4'd0;
    dumpWords = 4'd2;
    firstAt = 0;
    secondAt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      if (c == 1) #1 dumpStart = 1'b0;
      @(negedge clk);
      if (c == 1) checkOutput("cpuEnDrop", 32'(beCpuEnable), 32'h0);
      if (beOutValid) begin
        if (firstAt == 0) firstAt = c;
        else if (secondAt == 0) secondAt = c;
      end
    end
    checkOutput("firstLatency", 32'(firstAt), 32'd6);
    checkOutput("wordPeriod", 32'(secondAt - firstAt), 32'd5);
    waitIdle(20);

    // Backpressure on the first word
    outReady = 1'b0;
    pushDump(4'd0, 2);
    startDump(4'd0, 4'd2);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (beOutValid) begin
        got = 1;
        break;
      end
    end
    checkOutput("bpValidSeen", 32'(got), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpValidHeld", 32'(beOutValid), 32'h1);
      checkOutput("bpWordStable", beOutWord, 32'h01020304);
      checkOutput("bpLeWordStable", leOutWord, 32'h04030201);
      checkOutput("bpNoRead", 32'(beRe), 32'h0);
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    waitIdle(30);

    // Overflow: 17 bytes into a 16-byte RAM with no last marker
    doReset();
    startDump(4'd0, 4'd1);
    @(negedge clk);
    checkOutput("loadIgnoresDump", 32'({beRe, beCpuEnable}), 32'h0);
    foreach (overTab[i]) applyStimulus(overTab[i]);
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    checkOutput("ovfFlag", 32'(beOverflow), 32'h1);
    checkOutput("ovfCpuEn", 32'(beCpuEnable), 32'h1);
    checkOutput("ovfLoaded", 32'(beLoaded), 32'h0);
    checkOutput("ovfByteCount", 32'(beByteCount), 32'd16);
    checkOutput("ovfNoWrap", 32'(ramBe[0]), 32'h10);
    checkOutput("ovfTop", 32'(ramBe[15]), 32'h1F);

    // Zero-length dump request is ignored
    startDump(4'd3, 4'd0);
    @(negedge clk);
    checkOutput("zeroDumpIgnored", 32'({beRe, beCpuEnable}), 32'h1);

    // Dump wrapping past the top of memory
    pushDump(4'd14, 1);
    readAddrs.delete();
    logReads = 1'b1;
    startDump(4'd14, 4'd1);
    waitIdle(20);
    logReads = 1'b0;
    checkOutput("wrapReadCount", 32'(readAddrs.size()), 32'd4);
    for (int k = 0; k < 4 && k < readAddrs.size(); k++) begin
      expRd = 4'd14 + 4'(k);
      checkOutput("wrapReadAddr", 32'(readAddrs[k]), 32'(expRd));
    end

    // Asynchronous reset in the middle of a dump
    startDump(4'd0, 4'd2);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstRe", 32'(beRe), 32'h0);
    checkOutput("midRstOutValid", 32'(beOutValid), 32'h0);
    checkOutput("midRstCpuEn", 32'(beCpuEnable), 32'h0);
    checkOutput("midRstInReady", 32'(beReady), 32'h1);
    checkOutput("midRstLoaded", 32'(beLoaded), 32'h0);
    checkOutput("midRstByteCount", 32'(beByteCount), 32'h0);
    checkOutput("midRstOverflow", 32'(beOverflow), 32'h0);
    checkOutput("midRstLeInReady", 32'(leReady), 32'h1);
    qBe.delete();
    qLe.delete();
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_load_dump.md
Name: prog_load_dump

Overview:
- Hardware replacement for bench-side program preload and memory dump around the CPU.
- LOAD: accepts a byte stream and writes it into the byte-addressed RAM from address 0 while holding the CPU idle.
- RUN: releases the CPU.
- DUMP: on request, reads consecutive memory bytes and emits them as assembled big-endian words on an output stream.
- Sits between the test/boot interface, the RAM write/read port mux, and the CPU enable.

Parameters:
ADDR_W, 8, RAM byte-address width (depth 2^ADDR_W bytes)
BYTE_W, 8, width of one memory location
WORD_BYTES, 4, bytes per dumped word (>=1)
BIG_ENDIAN, 1, 1: lowest address is the word MSB; 0: lowest address is the LSB

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  reset; asynchronous, active-low
in_valid  in  1  load byte valid
in_data  in  BYTE_W  load byte
in_last  in  1  marks final byte of the program
in_ready  out  1  load byte accepted when in_valid & in_ready
mem_addr  out  ADDR_W  RAM byte address
mem_wdata  out  BYTE_W  RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe; mem_rdata valid the following cycle
mem_rdata  in  BYTE_W  RAM read data
dump_start  in  1  one-cycle dump request (sampled in RUN only)
dump_base  in  ADDR_W  dump start byte address
dump_words  in  ADDR_W  number of words to dump (0 = none)
out_valid  out  1  dump word valid
out_word  out  WORD_BYTES*BYTE_W  assembled word
out_addr  out  ADDR_W  byte address of the word's first byte
out_ready  in  1  dump consumer ready
cpu_enable  out  1  CPU Enable; high only in RUN
loaded  out  1  sticky; set when in_last is accepted
byte_count  out  ADDR_W+1  bytes written during LOAD
overflow  out  1  sticky; a load byte was offered beyond the RAM capacity

Behaviour:
- Reset values (Clear low): state LOAD, all outputs 0, except in_ready=1. Reset is asynchronous and overrides any operation in progress.
- State LOAD:
  - in_ready=1 while byte_count < 2^ADDR_W.
  - On accept, in the same cycle: mem_we=1, mem_addr=byte_count[ADDR_W-1:0], mem_wdata=in_data. byte_count increments next edge.
  - If in_last is accepted, the next state is RUN and loaded is set.
  - When byte_count == 2^ADDR_W: in_ready=0, no write occurs (no wrap to 0), and in_valid sets overflow. The state moves to RUN next cycle even without in_last.
- State RUN:
  - cpu_enable=1; memory port outputs held 0.
  - dump_start with dump_words != 0: latch base and count, cpu_enable drops next cycle, go to RD.
  - dump_start with dump_words == 0 is ignored.
- State RD (one byte per cycle):
  - mem_re=1 and mem_addr=cur; data is captured the cycle after.
  - Bytes are shifted into the word per BIG_ENDIAN; WORD_BYTES reads plus 1 capture cycle per word.
  - Addresses wrap modulo 2^ADDR_W.
- State OUT:
  - out_valid=1; out_word and out_addr stay stable until out_valid & out_ready.
  - On that handshake: decrement the remaining count; if nonzero go to RD, else go to RUN.
  - out_valid never drops without a handshake.
- Timing: first word latency after dump_start is WORD_BYTES+2 cycles with out_ready=1. Steady state is one word per WORD_BYTES+1 cycles.
- dump_start outside RUN is ignored. in_valid outside LOAD is ignored (in_ready=0).
- mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- Stream 8 bytes 0x01..0x08 with in_last on the 8th -> RAM[0..7]=01..08, byte_count=8, loaded=1, cpu_enable=1 one cycle after the last accept.
- Dump with dump_base=0, dump_words=2, out_ready=1, BIG_ENDIAN=1 -> out_word=0x01020304 @ addr 0, then 0x05060708 @ addr 4; first out_valid 6 cycles after dump_start; returns to RUN.
- Same dump with BIG_ENDIAN=0 -> 0x04030201, then 0x08070605.
- Hold out_ready=0 for 5 cycles on the first word -> out_word stable, no extra mem_re, count unchanged; release -> second word follows.
- With ADDR_W=4, stream 17 bytes without in_last -> 16 writes, 17th not written, overflow=1, state RUN. Dump base=14, words=1 -> reads addresses 14, 15, 0, 1.
- Drop Clear mid-dump -> outputs clear immediately, state LOAD, in_ready=1, loaded=0, byte_count=0.
